// File: rtl/branch_predict_unit.sv
// Direct-mapped branch predictor: 2-bit counters plus jump entries, resolved in execute. Optional BRANCH_STATS_EN adds counters.
// Latency: fetch lookup and execute outputs are combinational; the table updates on the next rising edge.
// Backpressure: none; a resolving instruction is consumed in the cycle it is presented.
module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] Cur_PC,
    input  logic [31:0]     Imm,
    input  logic            Branch,
    input  logic            jump,
    input  logic [31:0]     AluResult,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    output logic [31:0]     PC_Imm,
    output logic [31:0]     PC_Four,
    output logic            mispredict,
    output logic [31:0]     redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);
    localparam int  IDX_W     = $clog2(ENTRIES);
    localparam bit  TAG_EMPTY = (PC_W <= IDX_W + 2);
    localparam int  TAG_W     = TAG_EMPTY ? 1 : PC_W - IDX_W - 2;

    // Shift-based extraction keeps narrow PC_W / wide ENTRIES combinations legal.
    function automatic logic [IDX_W-1:0] pc_idx(input logic [PC_W-1:0] pc);
        logic [PC_W-1:0] s;
        s = pc >> 2;
        return IDX_W'(s);
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_W-1:0] pc);
        logic [PC_W-1:0] s;
        s = pc >> (IDX_W + 2);
        if (TAG_EMPTY) return '0;
        return TAG_W'(s);
    endfunction

    logic [ENTRIES-1:0]             vld_q;
    logic [ENTRIES-1:0]             jmp_q;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
    logic [ENTRIES-1:0][31:0]       tgt_q;
    logic [ENTRIES-1:0][1:0]        ctr_q;

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic             actual_taken;
    logic             upd;
    logic [31:0]      pc_ext;

    assign f_idx       = pc_idx(fetch_pc);
    assign f_tag       = pc_tag(fetch_pc);
    assign f_hit       = vld_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken  = f_hit && (jmp_q[f_idx] || ctr_q[f_idx][1]);
    assign pred_target = pred_taken ? tgt_q[f_idx] : 32'd0;

    assign pc_ext       = 32'(Cur_PC);
    assign PC_Imm       = pc_ext + Imm;
    assign PC_Four      = pc_ext + 32'd4;
    assign actual_taken = ex_valid && ((Branch && AluResult[0]) || jump);
    assign mispredict   = ex_valid && ((ex_pred_taken != actual_taken) ||
                                       (actual_taken && (ex_pred_target != PC_Imm)));
    assign redirect_pc  = !mispredict ? 32'd0 : (actual_taken ? PC_Imm : PC_Four);

    assign e_idx = pc_idx(Cur_PC);
    assign e_tag = pc_tag(Cur_PC);
    assign e_hit = vld_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign upd   = ex_valid && (Branch || jump);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                vld_q[i] <= 1'b0;
                jmp_q[i] <= 1'b0;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else if (upd) begin
            if (jump) begin
                // Jump wins over Branch when both are flagged.
                vld_q[e_idx] <= 1'b1;
                jmp_q[e_idx] <= 1'b1;
                tag_q[e_idx] <= e_tag;
                tgt_q[e_idx] <= PC_Imm;
                ctr_q[e_idx] <= 2'b11;
            end else if (e_hit) begin
                jmp_q[e_idx] <= 1'b0;
                if (AluResult[0]) begin
                    tgt_q[e_idx] <= PC_Imm;
                    if (ctr_q[e_idx] != 2'b11) ctr_q[e_idx] <= ctr_q[e_idx] + 2'b01;
                end else if (ctr_q[e_idx] != 2'b00) begin
                    ctr_q[e_idx] <= ctr_q[e_idx] - 2'b01;
                end
            end else if (AluResult[0]) begin
                vld_q[e_idx] <= 1'b1;
                jmp_q[e_idx] <= 1'b0;
                tag_q[e_idx] <= e_tag;
                tgt_q[e_idx] <= PC_Imm;
                ctr_q[e_idx] <= 2'b10;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (upd)        stat_branches    <= stat_branches + 32'd1;
            if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench for branch_predict_unit (PC_W=9, ENTRIES=16: index = pc[5:2], tag = pc[8:6]).
module tb_branch_predict_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [8:0]  Cur_PC;
    logic [31:0] Imm;
    logic        Branch;
    logic        jump;
    logic [31:0] AluResult;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] PC_Imm;
    logic [31:0] PC_Four;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_vec = 0;
    int n_err = 0;

    branch_predict_unit #(.PC_W(9), .ENTRIES(16)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .Cur_PC(Cur_PC), .Imm(Imm),
        .Branch(Branch), .jump(jump), .AluResult(AluResult),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .PC_Imm(PC_Imm), .PC_Four(PC_Four),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [8:0] pc, input logic [31:0] imm,
                       input logic br, input logic jmp, input logic alu,
                       input logic ept, input logic [31:0] epg);
        ex_valid = v; Cur_PC = pc; Imm = imm; Branch = br; jump = jmp;
        AluResult = {31'd0, alu}; ex_pred_taken = ept; ex_pred_target = epg;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ex_valid = 1'b0; Branch = 1'b0; jump = 1'b0; ex_pred_taken = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [8:0] pc, input logic t, input logic [31:0] tgt);
        fetch_pc = pc;
        #1;
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, t});
        chk({tag, ".target"}, pred_target, tgt);
    endtask

    task automatic chk_ex(input string tag, input logic mp, input logic [31:0] rd);
        chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, mp});
        chk({tag, ".redirect"}, redirect_pc, rd);
    endtask

    initial begin
        rst_n = 1'b0; fetch_pc = 9'h040;
        drv(1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        // Reset state; execute outputs stay live during reset; edge in reset must not update.
        look("rst", 9'h040, 1'b0, 32'h0);
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk_ex("rst_ex", 1'b1, 32'h60);
        chk("rst_pc4", PC_Four, 32'h44);
        @(posedge clk); #1;
        rst_n = 1'b1; ex_valid = 1'b0; #1;
        look("rst_noupd", 9'h040, 1'b0, 32'h0);

        // Allocate on taken miss.
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk_ex("alloc", 1'b1, 32'h60);
        chk("alloc_pcimm", PC_Imm, 32'h60);
        step();
        look("alloc_look", 9'h040, 1'b1, 32'h60);

        // Counter walk: 10 -> 01 -> 00 -> 01 -> 10 -> 11 (x4) -> 10 -> 01.
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 32'h60);
        chk_ex("nt1", 1'b1, 32'h44);
        step(); look("ctr01", 9'h040, 1'b0, 32'h0);
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_ex("nt2", 1'b0, 32'h0);
        step(); look("ctr00", 9'h040, 1'b0, 32'h0);
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(); look("ctr01b", 9'h040, 1'b0, 32'h0);
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(); look("ctr10", 9'h040, 1'b1, 32'h60);
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b1, 32'h60);
        chk_ex("t_ok", 1'b0, 32'h0);
        step();
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b1, 32'h64);
        chk_ex("t_badtgt", 1'b1, 32'h60);
        step();
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b1, 32'h60);
            step();
        end
        look("ctr11", 9'h040, 1'b1, 32'h60);
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 32'h60);
        step(); look("sat_10", 9'h040, 1'b1, 32'h60);
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 32'h60);
        step(); look("sat_01", 9'h040, 1'b0, 32'h0);

        // Jump with negative immediate; Branch+jump with false condition stays a jump.
        drv(1'b1, 9'h010, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("jmp_pcimm", PC_Imm, 32'h8);
        chk_ex("jmp", 1'b1, 32'h8);
        step(); look("jmp_look", 9'h010, 1'b1, 32'h8);
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 9'h010, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8);
            chk_ex("brjmp", 1'b0, 32'h0);
            step();
        end
        look("brjmp_look", 9'h010, 1'b1, 32'h8);

        // Aliasing on index 1: 0x04 then 0x44.
        drv(1'b1, 9'h004, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(); look("alias_a", 9'h004, 1'b1, 32'h14);
        drv(1'b1, 9'h044, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(); look("alias_b", 9'h044, 1'b1, 32'h4C);
        look("alias_a_miss", 9'h004, 1'b0, 32'h0);
        drv(1'b1, 9'h084, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(); look("miss_nt", 9'h044, 1'b1, 32'h4C);
        drv(1'b1, 9'h044, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4C);
        chk_ex("stale", 1'b1, 32'h48);
        step(); look("stale_hold", 9'h044, 1'b1, 32'h4C);

        // Same-cycle lookup and update returns old contents.
        drv(1'b1, 9'h044, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4C);
        look("bypass_old", 9'h044, 1'b1, 32'h4C);
        step(); look("bypass_new", 9'h044, 1'b0, 32'h0);

        // ex_valid low: no update.
        drv(1'b0, 9'h00C, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk_ex("novalid", 1'b0, 32'h0);
        step(); look("novalid_look", 9'h00C, 1'b0, 32'h0);

        // Asynchronous reset clears the table without a clock edge.
        @(negedge clk);
        look("pre_arst", 9'h010, 1'b1, 32'h8);
        rst_n = 1'b0; #1;
        look("arst", 9'h010, 1'b0, 32'h0);
        rst_n = 1'b1; #1;

`ifdef BRANCH_STATS_EN
        chk("stat_b0", stat_branches, 32'd0);
        chk("stat_m0", stat_mispredicts, 32'd0);
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);  step();
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b1, 32'h60); step();
        drv(1'b0, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);  step();
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b1, 1'b1, 32'h60); step();
        drv(1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 32'h60); step();
        drv(1'b1, 9'h010, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8); step();
        chk("stat_b5", stat_branches, 32'd5);
        chk("stat_m2", stat_mispredicts, 32'd2);
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk("stat_b_rst", stat_branches, 32'd0);
        chk("stat_m_rst", stat_mispredicts, 32'd0);
        rst_n = 1'b1; #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
